tp_wram_arbiter: RTL and testbench

- Shares the single-port main-CPU work RAM between the main Z80 bus and the MiSTer hiscore port (hs_address/hs_data_in/hs_data_out/hs_write).
- Sits inside the main PCB, between the CPU address decode, the work-RAM instance and the hiscore top-level signals.
- The CPU always has priority. Hiscore accesses are slotted into idle cycles between CPU clock enables.
- A starvation guard stalls the CPU through cpu_wait_n if a hiscore request waits too long.

---
 rtl/tp_arb_pkg.sv | 15 +
 rtl/tp_wram_arbiter.sv | 160 ++++++++++++++++
 tb/tb_tp_wram_arbiter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tp_arb_pkg.sv
// Shared types and default widths for the main-CPU work-RAM arbiter.
package tp_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CPU_ACC,
    CPU_DAT,
    HS_ACC,
    HS_DAT
  } arb_state_t;

  localparam int TP_WRAM_AW = 11;
  localparam int TP_WRAM_DW = 8;

endpackage

// File: rtl/tp_wram_arbiter.sv
// Work-RAM arbiter: Z80 bus has priority, hiscore port fills idle slots, starvation guard stalls the CPU.
// Optional macro TP_HS_PAUSE_ONLY_EN adds a pause input; hiscore grants then happen only while pause=1.
module tp_wram_arbiter
  import tp_arb_pkg::*;
#(
  parameter int ADDR_W        = TP_WRAM_AW,
  parameter int DATA_W        = TP_WRAM_DW,
  parameter int HS_STARVE_MAX = 64
) (
  input  logic              clk_49m,
  input  logic              reset,
`ifdef TP_HS_PAUSE_ONLY_EN
  input  logic              pause,
`endif
  input  logic              cpu_ce,
  input  logic              cpu_cs,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_din,
  output logic [DATA_W-1:0] cpu_dout,
  output logic              cpu_wait_n,
  input  logic              hs_req,
  input  logic              hs_we,
  input  logic [ADDR_W-1:0] hs_addr,
  input  logic [DATA_W-1:0] hs_din,
  output logic [DATA_W-1:0] hs_dout,
  output logic              hs_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam int CNT_W = $clog2(HS_STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HS_STARVE_MAX);

  arb_state_t        state_q, state_d;
  logic              cpu_pend_q, cpu_pend_d;
  logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
  logic              lat_we_q, lat_we_d;
  logic [DATA_W-1:0] lat_din_q, lat_din_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] cpu_dout_q, cpu_dout_d;
  logic [DATA_W-1:0] hs_dout_q, hs_dout_d;
  logic              hs_ack_q, hs_ack_d;

  logic hs_req_eff;
  logic starve;
  logic cpu_hit;
  logic ram_we_raw;

`ifdef TP_HS_PAUSE_ONLY_EN
  assign hs_req_eff = hs_req & pause;
`else
  assign hs_req_eff = hs_req;
`endif

  assign starve  = (cnt_q == CNT_MAX);
  // While the CPU is being stalled its strobes are not real accesses.
  assign cpu_hit = cpu_ce & cpu_cs & ~starve;

  always_comb begin
    state_d    = state_q;
    cpu_pend_d = cpu_pend_q;
    lat_addr_d = lat_addr_q;
    lat_we_d   = lat_we_q;
    lat_din_d  = lat_din_q;
    cnt_d      = cnt_q;
    cpu_dout_d = cpu_dout_q;
    hs_dout_d  = hs_dout_q;

    case (state_q)
      IDLE: begin
        if (starve && hs_req_eff)          state_d = HS_ACC;
        else if (cpu_pend_q || cpu_hit)    state_d = CPU_ACC;
        else if (hs_req_eff)               state_d = HS_ACC;
      end
      CPU_ACC: begin
        cpu_pend_d = 1'b0;
        state_d    = CPU_DAT;
      end
      CPU_DAT: begin
        if (!lat_we_q) cpu_dout_d = ram_dout;
        state_d = IDLE;
      end
      HS_ACC:  state_d = HS_DAT;
      HS_DAT: begin
        if (!hs_we) hs_dout_d = ram_dout;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Capture after the case so a strobe landing in CPU_ACC is not lost.
    if (cpu_hit) begin
      cpu_pend_d = 1'b1;
      lat_addr_d = cpu_addr;
      lat_we_d   = cpu_we;
      lat_din_d  = cpu_din;
    end

    if (!hs_req_eff || state_q == HS_DAT)
      cnt_d = '0;
    else if (state_q != HS_ACC && !starve)
      cnt_d = cnt_q + 1'b1;

    hs_ack_d = (state_d == HS_DAT);
  end

  always_comb begin
    ram_addr   = '0;
    ram_din    = '0;
    ram_we_raw = 1'b0;
    case (state_q)
      CPU_ACC: begin
        ram_addr   = lat_addr_q;
        ram_din    = lat_din_q;
        ram_we_raw = lat_we_q;
      end
      HS_ACC: begin
        ram_addr   = hs_addr;
        ram_din    = hs_din;
        ram_we_raw = hs_we;
      end
      default: ;
    endcase
  end

  // Gating with reset keeps an abandoned write from reaching the RAM on the reset edge.
  assign ram_we     = ram_we_raw & reset;
  assign cpu_wait_n = ~(starve && state_q != HS_DAT);
  assign cpu_dout   = cpu_dout_q;
  assign hs_dout    = hs_dout_q;
  assign hs_ack     = hs_ack_q;

  always_ff @(posedge clk_49m) begin
    if (!reset) begin
      state_q    <= IDLE;
      cpu_pend_q <= 1'b0;
      lat_addr_q <= '0;
      lat_we_q   <= 1'b0;
      lat_din_q  <= '0;
      cnt_q      <= '0;
      cpu_dout_q <= '0;
      hs_dout_q  <= '0;
      hs_ack_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cpu_pend_q <= cpu_pend_d;
      lat_addr_q <= lat_addr_d;
      lat_we_q   <= lat_we_d;
      lat_din_q  <= lat_din_d;
      cnt_q      <= cnt_d;
      cpu_dout_q <= cpu_dout_d;
      hs_dout_q  <= hs_dout_d;
      hs_ack_q   <= hs_ack_d;
    end
  end

endmodule

// File: tb/tb_tp_wram_arbiter.sv
// Directed bench for tp_wram_arbiter with a 1-clk-latency RAM model and HS_STARVE_MAX=4.
module tb_tp_wram_arbiter;

  localparam int AW = 11;
  localparam int DW = 8;

  logic          clk_49m = 1'b0;
  logic          reset = 1'b0;
  logic          cpu_ce = 1'b0, cpu_cs = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_din = '0;
  logic [DW-1:0] cpu_dout;
  logic          cpu_wait_n;
  logic          hs_req = 1'b0, hs_we = 1'b0;
  logic [AW-1:0] hs_addr = '0;
  logic [DW-1:0] hs_din = '0;
  logic [DW-1:0] hs_dout;
  logic          hs_ack;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_pass = 0;
  int n_total = 0;
  logic ack_seen, we_seen;

  always #10 clk_49m = ~clk_49m;

  always @(posedge clk_49m) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  tp_wram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .HS_STARVE_MAX(4)) dut (
    .clk_49m(clk_49m),
    .reset(reset),
`ifdef TP_HS_PAUSE_ONLY_EN
    .pause(1'b1),
`endif
    .cpu_ce(cpu_ce), .cpu_cs(cpu_cs), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .cpu_wait_n(cpu_wait_n),
    .hs_req(hs_req), .hs_we(hs_we), .hs_addr(hs_addr), .hs_din(hs_din),
    .hs_dout(hs_dout), .hs_ack(hs_ack),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  task automatic tick();
    @(posedge clk_49m);
    #1;
    ack_seen = ack_seen | hs_ack;
    we_seen  = we_seen | ram_we;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    tick();
    bd_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    preload(11'h7FF, 8'h3C);
    preload(11'h055, 8'h5A);
    preload(11'h010, 8'h11);
    preload(11'h066, 8'h00);
    preload(11'h123, 8'h00);
    preload(11'h200, 8'h00);
    preload(11'h301, 8'h00);
    n_total++; if ({cpu_dout, hs_dout, hs_ack, ram_we} !== 18'h0)
      $display("FAIL reset_outs: cpu_dout=%h hs_dout=%h ack=%b we=%b want 0", cpu_dout, hs_dout, hs_ack, ram_we);
    else n_pass++;
    n_total++; if ({ram_addr, ram_din} !== 19'h0)
      $display("FAIL reset_ram: addr=%h din=%h want 0", ram_addr, ram_din);
    else n_pass++;
    n_total++; if (cpu_wait_n !== 1'b1) $display("FAIL reset_wait: got %b want 1", cpu_wait_n);
    else n_pass++;
    reset = 1'b1;
    idle(3);
  endtask

  task automatic test_cpu_write_read();
    ack_seen = 1'b0;
    cpu_ce = 1; cpu_cs = 1; cpu_we = 1; cpu_addr = 11'h123; cpu_din = 8'hA5;
    tick();
    cpu_ce = 0; cpu_cs = 0; cpu_we = 0;
    n_total++; if ({ram_we, ram_addr, ram_din} !== {1'b1, 11'h123, 8'hA5})
      $display("FAIL cpu_wr_bus: we=%b addr=%h din=%h want 1/123/a5", ram_we, ram_addr, ram_din);
    else n_pass++;
    tick();
    n_total++; if (ram_we !== 1'b0) $display("FAIL cpu_wr_1clk: we=%b want 0", ram_we);
    else n_pass++;
    tick();
    n_total++; if (cpu_dout !== 8'h00) $display("FAIL cpu_wr_dout: got %h want 00", cpu_dout);
    else n_pass++;
    n_total++; if (mem[11'h123] !== 8'hA5) $display("FAIL cpu_wr_mem: got %h want a5", mem[11'h123]);
    else n_pass++;
    idle(13);
    cpu_ce = 1; cpu_cs = 1; cpu_we = 0; cpu_addr = 11'h123;
    tick();
    cpu_ce = 0; cpu_cs = 0;
    n_total++; if ({ram_we, ram_addr} !== {1'b0, 11'h123})
      $display("FAIL cpu_rd_bus: we=%b addr=%h want 0/123", ram_we, ram_addr);
    else n_pass++;
    tick();
    n_total++; if (cpu_dout !== 8'h00) $display("FAIL cpu_rd_early: got %h want 00", cpu_dout);
    else n_pass++;
    tick();
    n_total++; if (cpu_dout !== 8'hA5) $display("FAIL cpu_rd_data: got %h want a5", cpu_dout);
    else n_pass++;
    n_total++; if (ack_seen !== 1'b0) $display("FAIL cpu_no_ack: ack_seen=%b want 0", ack_seen);
    else n_pass++;
    idle(16);
  endtask

  task automatic test_hs_read();
    hs_req = 1; hs_we = 0; hs_addr = 11'h7FF;
    tick();
    n_total++; if ({ram_we, ram_addr, hs_ack} !== {1'b0, 11'h7FF, 1'b0})
      $display("FAIL hs_acc: we=%b addr=%h ack=%b want 0/7ff/0", ram_we, ram_addr, hs_ack);
    else n_pass++;
    tick();
    n_total++; if (hs_ack !== 1'b1) $display("FAIL hs_ack: got %b want 1", hs_ack);
    else n_pass++;
    hs_req = 0;
    tick();
    n_total++; if ({hs_ack, hs_dout} !== {1'b0, 8'h3C})
      $display("FAIL hs_data: ack=%b dout=%h want 0/3c", hs_ack, hs_dout);
    else n_pass++;
    ack_seen = 1'b0;
    idle(4);
    n_total++; if (ack_seen !== 1'b0) $display("FAIL hs_no_repeat: ack_seen=%b want 0", ack_seen);
    else n_pass++;
    idle(12);
  endtask

  // CPU strobe lands in HS_ACC: hiscore finishes first, CPU result 5 clk after its strobe.
  task automatic test_worst_case(input logic wr);
    hs_req = 1; hs_we = ~wr; hs_addr = wr ? 11'h7FF : 11'h200; hs_din = 8'hC3;
    tick();
    n_total++; if ({ram_we, ram_addr} !== {~wr, hs_addr})
      $display("FAIL wc_hs_acc: we=%b addr=%h want %b/%h", ram_we, ram_addr, ~wr, hs_addr);
    else n_pass++;
    cpu_ce = 1; cpu_cs = 1; cpu_we = wr; cpu_addr = wr ? 11'h301 : 11'h200; cpu_din = 8'h81;
    tick();
    cpu_ce = 0; cpu_cs = 0; cpu_we = 0;
    n_total++; if (hs_ack !== 1'b1) $display("FAIL wc_ack: got %b want 1", hs_ack);
    else n_pass++;
    hs_req = 0;
    tick();
    tick();
    n_total++; if ({ram_we, ram_addr} !== {wr, cpu_addr})
      $display("FAIL wc_cpu_acc: we=%b addr=%h want %b/%h", ram_we, ram_addr, wr, cpu_addr);
    else n_pass++;
    tick();
    if (!wr) begin
      n_total++; if (cpu_dout !== 8'hA5) $display("FAIL wc_rd_early: got %h want a5", cpu_dout);
      else n_pass++;
    end
    tick();
    if (!wr) begin
      n_total++; if (cpu_dout !== 8'hC3) $display("FAIL wc_rd_data: got %h want c3", cpu_dout);
      else n_pass++;
    end else begin
      n_total++; if (mem[11'h301] !== 8'h81) $display("FAIL wc_wr_mem: got %h want 81", mem[11'h301]);
      else n_pass++;
    end
    idle(16);
  endtask

  task automatic test_simul_starve();
    cpu_ce = 1; cpu_cs = 1; cpu_we = 0; cpu_addr = 11'h055;
    hs_req = 1; hs_we = 0; hs_addr = 11'h200;
    tick();
    cpu_ce = 0; cpu_cs = 0;
    n_total++; if (ram_addr !== 11'h055) $display("FAIL sim_cpu_first: addr=%h want 055", ram_addr);
    else n_pass++;
    tick();
    tick();
    n_total++; if ({cpu_dout, cpu_wait_n} !== {8'h5A, 1'b1})
      $display("FAIL sim_cpu_data: dout=%h wait_n=%b want 5a/1", cpu_dout, cpu_wait_n);
    else n_pass++;
    tick();
    n_total++; if ({cpu_wait_n, ram_addr} !== {1'b0, 11'h200})
      $display("FAIL starve_wait: wait_n=%b addr=%h want 0/200", cpu_wait_n, ram_addr);
    else n_pass++;
    cpu_ce = 1; cpu_cs = 1; cpu_we = 1; cpu_addr = 11'h066; cpu_din = 8'h77;
    tick();
    cpu_ce = 0; cpu_cs = 0; cpu_we = 0;
    n_total++; if ({hs_ack, cpu_wait_n} !== 2'b11)
      $display("FAIL starve_release: ack=%b wait_n=%b want 1/1", hs_ack, cpu_wait_n);
    else n_pass++;
    hs_req = 0;
    we_seen = 1'b0;
    tick();
    n_total++; if (hs_dout !== 8'hC3) $display("FAIL sim_hs_data: got %h want c3", hs_dout);
    else n_pass++;
    idle(5);
    n_total++; if ({we_seen, mem[11'h066]} !== 9'h000)
      $display("FAIL starve_suppress: we_seen=%b mem066=%h want 0/00", we_seen, mem[11'h066]);
    else n_pass++;
    idle(16);
  endtask

  task automatic test_reset_mid();
    cpu_ce = 1; cpu_cs = 1; cpu_we = 1; cpu_addr = 11'h010; cpu_din = 8'hEE;
    tick();
    cpu_ce = 0; cpu_cs = 0; cpu_we = 0;
    n_total++; if (ram_we !== 1'b1) $display("FAIL rst_pre_we: got %b want 1", ram_we);
    else n_pass++;
    reset = 0;
    #1;
    n_total++; if (ram_we !== 1'b0) $display("FAIL rst_we_gate: got %b want 0", ram_we);
    else n_pass++;
    tick();
    n_total++; if ({cpu_dout, hs_dout, hs_ack, ram_we, ram_addr, ram_din} !== 37'h0)
      $display("FAIL rst_mid_outs: cpu=%h hs=%h ack=%b we=%b addr=%h din=%h want 0",
               cpu_dout, hs_dout, hs_ack, ram_we, ram_addr, ram_din);
    else n_pass++;
    n_total++; if ({cpu_wait_n, mem[11'h010]} !== {1'b1, 8'h11})
      $display("FAIL rst_mid_mem: wait_n=%b mem010=%h want 1/11", cpu_wait_n, mem[11'h010]);
    else n_pass++;
    reset = 1;
    we_seen = 1'b0;
    idle(4);
    n_total++; if (we_seen !== 1'b0) $display("FAIL rst_pend_clr: we_seen=%b want 0", we_seen);
    else n_pass++;
  endtask

  initial begin
    ack_seen = 1'b0;
    we_seen  = 1'b0;
    test_reset();
    test_cpu_write_read();
    test_hs_read();
    test_worst_case(1'b0);
    test_worst_case(1'b1);
    test_simul_starve();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
